// File: rtl/ddr_rd_unpack_pkg.sv
// Shared widths, types and the beat-slice helper for the DDR read-back
// unpacker (256-bit MIG words split into eight 32-bit uplink beats).
package ddr_rd_unpack_pkg;

    localparam int DDR_WORD_W     = 256;
    localparam int BEAT_W         = 32;
    localparam int BEATS_PER_WORD = 8;
    localparam int LANE_W         = 3;

    typedef logic [DDR_WORD_W-1:0] ddr_word_t;
    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [LANE_W-1:0]     lane_t;

    localparam lane_t LAST_LANE = lane_t'(BEATS_PER_WORD - 1);
    localparam lane_t LANE_ONE  = lane_t'(1);

    // Beat k of a word lives in bits [32k+31:32k]; lane 0 is sent first.
    function automatic beat_t beat_slice(input ddr_word_t word, input lane_t lane);
        return word[BEAT_W*lane +: BEAT_W];
    endfunction

endpackage

// File: rtl/ddr_rd_buf.sv
// Single-clock circular word buffer between the DDR FIFO top and the
// unpacker output stage. Writes cannot be back-pressured, so a write into a
// full buffer (with no simultaneous pop) is dropped and flagged in a sticky
// overflow bit. The almost-full throttle is a registered compare of the
// level register so it never glitches.
module ddr_rd_buf
    import ddr_rd_unpack_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int AFULL_MARGIN = 4,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int LVL_W        = PTR_W + 1
) (
    input  logic             ui_clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  ddr_word_t        wr_data,
    input  logic             pop,
    output ddr_word_t        rd_data,
    output logic [LVL_W-1:0] level,
    output logic             almost_full,
    output logic             ovf
);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] AFULL_TH = LVL_W'(DEPTH - AFULL_MARGIN);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    ddr_word_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             afull_q;
    logic             ovf_q;
    logic             push;
    logic             drop;

    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    always_comb begin
        push = wr_en && ((level_q != LVL_FULL) || pop);
        drop = wr_en && (level_q == LVL_FULL) && !pop;
    end

    // Storage array; no reset needed since pointers define what is valid.
    always_ff @(posedge ui_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, level, throttle and sticky overflow; flush beats everything.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_q <= level_q - LVL_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            // Compare the registered level so the throttle lags it by a cycle.
            afull_q <= (level_q >= AFULL_TH);
        end
    end

    assign rd_data     = mem[rd_ptr_q];
    assign level       = level_q;
    assign almost_full = afull_q;
    assign ovf         = ovf_q;

endmodule

// File: rtl/ddr_rd_unpack.sv
// DDR read-back unpacker. Buffers 256-bit words from the DDR FIFO top and
// streams each one as eight 32-bit beats (lane 0 first) on a valid/ready
// interface. The next word is loaded on the lane-7 handshake edge so beats
// stay gapless while the sink keeps m_ready high.
module ddr_rd_unpack
    import ddr_rd_unpack_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int AFULL_MARGIN = 4,
    localparam int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ddr_rd_en,
    input  logic [DDR_WORD_W-1:0] ddr_rd_data,
    output logic                  ddr_rd_full,
    output logic [BEAT_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  ovf
);

    ddr_word_t buf_word;
    ddr_word_t word_q;
    ddr_word_t word_d;
    lane_t     lane_q;
    lane_t     lane_d;
    logic      valid_q;
    logic      valid_d;
    logic      hs;
    logic      lane_last;
    logic      pop;

    ddr_rd_buf #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_buf (
        .ui_clk      (ui_clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (ddr_rd_en),
        .wr_data     (ddr_rd_data),
        .pop         (pop),
        .rd_data     (buf_word),
        .level       (fifo_level),
        .almost_full (ddr_rd_full),
        .ovf         (ovf)
    );

    // Output-stage next state: load on pop, otherwise advance on handshake.
    always_comb begin
        hs        = valid_q && m_ready;
        lane_last = (lane_q == LAST_LANE);
        pop       = (fifo_level != '0) && (!valid_q || (hs && lane_last));
        word_d    = word_q;
        lane_d    = lane_q;
        valid_d   = valid_q;
        if (pop) begin
            word_d  = buf_word;
            lane_d  = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            if (lane_last) begin
                lane_d  = '0;
                valid_d = 1'b0;
            end else begin
                lane_d = lane_q + LANE_ONE;
            end
        end
    end

    // Output-stage registers; flush drops the partially sent word.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = beat_slice(word_q, lane_q);
    assign m_valid = valid_q;
    assign m_last  = valid_q && lane_last;

endmodule

// File: tb/tb_ddr_rd_unpack.sv
// Directed bench for ddr_rd_unpack: a beat scoreboard filled when words are
// written and drained by a handshake monitor, plus level/throttle/overflow
// checks at fixed points in the sequence.
module tb_ddr_rd_unpack;
    import ddr_rd_unpack_pkg::*;

    localparam int LVL_W = 5;

    logic              ui_clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              ddr_rd_en;
    logic [255:0]      ddr_rd_data;
    logic              ddr_rd_full;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [LVL_W-1:0]  fifo_level;
    logic              ovf;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          beats_seen = 0;
    logic [63:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    ddr_rd_unpack #(.DEPTH(16), .AFULL_MARGIN(4)) dut (
        .ui_clk      (ui_clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ddr_rd_en   (ddr_rd_en),
        .ddr_rd_data (ddr_rd_data),
        .ddr_rd_full (ddr_rd_full),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .fifo_level  (fifo_level),
        .ovf         (ovf)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] beat_val(input int id, input int k);
        return 32'((id << 8) | k);
    endfunction

    function automatic logic [255:0] make_word(input int id);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = beat_val(id, k);
        return w;
    endfunction

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    // Drive one word; when accepted, its eight beats join the scoreboard.
    task automatic send(input int id, input bit accept);
        ddr_rd_en   = 1'b1;
        ddr_rd_data = make_word(id);
        if (accept) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back({31'b0, (k == 7), beat_val(id, k)});
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Handshake monitor: scoreboard compare and hold-while-stalled check.
    always @(negedge ui_clk) begin
        if (!rst_n || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() != 0)
                    check("beat", {31'b0, m_last, m_data}, exp_q.pop_front());
                else
                    check("beat_unexpected", {31'b0, m_last, m_data}, {64{1'bx}});
                beats_seen++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lvl, rem, sent, b0;
        bit full_m, push, pop;

        rst_n       = 1'b1;
        flush       = 1'b0;
        ddr_rd_en   = 1'b0;
        m_ready     = 1'b0;
        ddr_rd_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_full", 64'(ddr_rd_full), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge ui_clk);
        @(negedge ui_clk) rst_n = 1'b1;
        tick();

        // Single word, latency N+2, beats k = k.
        b0 = beats_seen;
        m_ready = 1'b1;
        send(0, 1'b1);
        tick();
        ddr_rd_en = 1'b0;
        check("t1_valid_n1", 64'(m_valid), 64'd0);
        check("t1_level_n1", 64'(fifo_level), 64'd1);
        tick();
        check("t1_valid_n2", 64'(m_valid), 64'd1);
        check("t1_beat0", 64'(m_data), 64'(beat_val(0, 0)));
        check("t1_last0", 64'(m_last), 64'd0);
        drain(50, "t1_drain");
        check("t1_idle", 64'(m_valid), 64'd0);
        check("t1_beats", 64'(beats_seen - b0), 64'd8);

        // 20 words, writer throttled by a model of ddr_rd_full.
        b0 = beats_seen;
        lvl = 0; rem = 0; sent = 0; full_m = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            push = (sent < 20) && !full_m;
            ddr_rd_en = push;
            if (push) begin
                send(100 + sent, 1'b1);
                sent++;
            end
            tick();
            pop    = (lvl > 0) && (rem <= 1);
            full_m = (lvl >= 12);
            rem    = pop ? 8 : ((rem > 0) ? rem - 1 : 0);
            lvl    = lvl + int'(push) - int'(pop);
            check("t2_level", 64'(fifo_level), 64'(lvl));
            check("t2_full", 64'(ddr_rd_full), 64'(full_m));
            check("t2_valid", 64'(m_valid), 64'(rem > 0));
            if (sent == 20 && lvl == 0 && rem == 0) break;
        end
        ddr_rd_en = 1'b0;
        check("t2_queue", 64'(exp_q.size()), 64'd0);
        check("t2_beats", 64'(beats_seen - b0), 64'd160);
        check("t2_ovf", 64'(ovf), 64'd0);

        // Stalled sink, 17 writes fill buffer + stage; 18th overflows.
        b0 = beats_seen;
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(200 + i, 1'b1);
            tick();
        end
        check("t3_level16", 64'(fifo_level), 64'd16);
        check("t3_valid", 64'(m_valid), 64'd1);
        check("t3_ovf0", 64'(ovf), 64'd0);
        send(217, 1'b0);
        tick();
        ddr_rd_en = 1'b0;
        check("t3_ovf1", 64'(ovf), 64'd1);
        check("t3_level_hold", 64'(fifo_level), 64'd16);
        m_ready = 1'b1;
        drain(300, "t3_drain");
        check("t3_beats", 64'(beats_seen - b0), 64'd136);
        check("t3_ovf_sticky", 64'(ovf), 64'd1);

        // Flush clears the sticky overflow.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_ovf", 64'(ovf), 64'd0);
        check("fl_level", 64'(fifo_level), 64'd0);

        // Full buffer, pop and write in the same cycle.
        b0 = beats_seen;
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(300 + i, 1'b1);
            tick();
        end
        ddr_rd_en = 1'b0;
        check("t4_level16", 64'(fifo_level), 64'd16);
        m_ready = 1'b1;
        repeat (7) tick();
        check("t4_lane7", 64'(m_last), 64'd1);
        send(317, 1'b1);
        tick();
        ddr_rd_en = 1'b0;
        check("t4_level_same", 64'(fifo_level), 64'd16);
        check("t4_ovf", 64'(ovf), 64'd0);
        drain(300, "t4_drain");
        check("t4_beats", 64'(beats_seen - b0), 64'd144);

        // Toggling m_ready across 4 words.
        b0 = beats_seen;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(400 + i, 1'b1);
            m_ready = !m_ready;
            tick();
        end
        ddr_rd_en = 1'b0;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            m_ready = !m_ready;
            tick();
        end
        check("t5_queue", 64'(exp_q.size()), 64'd0);
        check("t5_beats", 64'(beats_seen - b0), 64'd32);

        // Flush mid-word at lane 3 with level 5 and a concurrent write.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(500 + i, 1'b1);
            tick();
        end
        ddr_rd_en = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        check("t6_level5", 64'(fifo_level), 64'd5);
        check("t6_lane3", 64'(m_data), 64'(beat_val(500, 3)));
        exp_q.delete();
        flush = 1'b1;
        send(599, 1'b0);
        tick();
        flush = 1'b0;
        ddr_rd_en = 1'b0;
        check("t6_valid", 64'(m_valid), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        check("t6_ovf", 64'(ovf), 64'd0);
        check("t6_full", 64'(ddr_rd_full), 64'd0);
        b0 = beats_seen;
        m_ready = 1'b1;
        send(510, 1'b1);
        tick();
        send(511, 1'b1);
        tick();
        ddr_rd_en = 1'b0;
        check("t6_restart_beat0", 64'(m_data), 64'(beat_val(510, 0)));
        drain(100, "t6_drain");
        check("t6_beats", 64'(beats_seen - b0), 64'd16);

        // Asynchronous reset mid-stream drops the output immediately.
        m_ready = 1'b0;
        send(600, 1'b1);
        tick();
        ddr_rd_en = 1'b0;
        tick();
        check("t7_valid_pre", 64'(m_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_valid_async", 64'(m_valid), 64'd0);
        check("t7_data_async", 64'(m_data), 64'd0);
        check("t7_level_async", 64'(fifo_level), 64'd0);
        exp_q.delete();
        @(negedge ui_clk) rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (3) tick();
        check("t7_idle", 64'(m_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
